// File: rtl/mult_fu.sv
// Pipelined RV32M multiply unit: one op per cycle in, NUM_STAGES lockstep stages,
// result held in the last stage until the CDB takes it.
module mult_fu #(
   parameter int NUM_STAGES    = 4,
   parameter int PRN_WIDTH     = 6,
   parameter int ROB_CNT_WIDTH = 5
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     squash,
   input  logic                     issue_valid,
   input  logic [1:0]               issue_func,
   input  logic [31:0]              issue_rs1,
   input  logic [31:0]              issue_rs2,
   input  logic [PRN_WIDTH-1:0]     issue_dest_prn,
   input  logic [ROB_CNT_WIDTH-1:0] issue_robn,
   input  logic                     cdb_avail,
   output logic                     issue_ready,
   output logic                     prepared,
   output logic [ROB_CNT_WIDTH-1:0] out_robn,
   output logic [PRN_WIDTH-1:0]     out_dest_prn,
   output logic [31:0]              out_result
);

   localparam int W = 64 / NUM_STAGES;

   typedef enum logic [1:0] {
      FUNC_MUL    = 2'b00,
      FUNC_MULH   = 2'b01,
      FUNC_MULHSU = 2'b10,
      FUNC_MULHU  = 2'b11
   } func_e;

   typedef struct packed {
      logic                     valid;
      func_e                    func;
      logic [63:0]              mcand;
      logic [63:0]              mplier;
      logic [63:0]              sum;
      logic [PRN_WIDTH-1:0]     dest_prn;
      logic [ROB_CNT_WIDTH-1:0] robn;
   } stage_t;

   stage_t pipe      [NUM_STAGES];
   stage_t pipe_next [NUM_STAGES];
   stage_t entry;
   logic   advance;

   // Contribution of multiplier slice k, already shifted into its final position.
   function automatic logic [63:0] partial(input logic [63:0] mcand,
                                           input logic [63:0] mplier,
                                           input int          k);
      logic [63:0] chunk;
      chunk        = '0;
      chunk[W-1:0] = mplier[k*W +: W];
      return (mcand * chunk) << (k * W);
   endfunction

   assign prepared    = pipe[NUM_STAGES-1].valid;
   assign advance     = ~prepared | cdb_avail;
   assign issue_ready = advance & ~squash;

   always_comb begin
      // NOTE: every always_comb output gets a full default first so no path can infer a latch.
      entry          = '0;
      entry.valid    = issue_valid & issue_ready;
      entry.func     = func_e'(issue_func);
      entry.dest_prn = issue_dest_prn;
      entry.robn     = issue_robn;
      entry.mcand    = (entry.func == FUNC_MULH || entry.func == FUNC_MULHSU)
                       ? {{32{issue_rs1[31]}}, issue_rs1} : {32'b0, issue_rs1};
      entry.mplier   = (entry.func == FUNC_MULH)
                       ? {{32{issue_rs2[31]}}, issue_rs2} : {32'b0, issue_rs2};
      entry.sum      = partial(entry.mcand, entry.mplier, 0);
   end

   always_comb begin
      pipe_next[0] = entry;
      for (int k = 1; k < NUM_STAGES; k++) begin
         pipe_next[k]     = pipe[k-1];
         pipe_next[k].sum = pipe[k-1].sum + partial(pipe[k-1].mcand, pipe[k-1].mplier, k);
      end
   end

   // Squash beats advance; a stalled pipe holds every stage, bubbles included.
   always_ff @(posedge clock) begin
      if (reset) begin
         // NOTE: the stage array is reset in full (not just valids) so outputs read 0 after reset.
         for (int k = 0; k < NUM_STAGES; k++) pipe[k] <= '0;
      end else if (squash) begin
         // NOTE: state is updated with non-blocking assignments so all stages shift off the same old values.
         for (int k = 0; k < NUM_STAGES; k++) pipe[k].valid <= 1'b0;
      end else if (advance) begin
         for (int k = 0; k < NUM_STAGES; k++) pipe[k] <= pipe_next[k];
      end
   end

   assign out_robn     = pipe[NUM_STAGES-1].robn;
   assign out_dest_prn = pipe[NUM_STAGES-1].dest_prn;
   assign out_result   = (pipe[NUM_STAGES-1].func == FUNC_MUL)
                         ? pipe[NUM_STAGES-1].sum[31:0] : pipe[NUM_STAGES-1].sum[63:32];

endmodule

// File: tb/tb_mult_fu.sv
// Bench for mult_fu: depth-1, 4 and 8 instances share stimulus; each is checked against
// a slot-level model whose results come from a plain 64-bit multiply.
module tb_mult_fu;

   localparam int PW = 6;
   localparam int RW = 5;

   logic          clock = 1'b0;
   logic          reset, squash, issue_valid, cdb_avail;
   logic [1:0]    issue_func;
   logic [31:0]   issue_rs1, issue_rs2;
   logic [PW-1:0] issue_dest_prn;
   logic [RW-1:0] issue_robn;

   logic [2:0]    prep_w, rdy_w;
   logic [31:0]   res_w  [3];
   logic [PW-1:0] prn_w  [3];
   logic [RW-1:0] robn_w [3];

   logic          mv   [3][8];
   logic [31:0]   mres [3][8];
   logic [PW-1:0] mprn [3][8];
   logic [RW-1:0] mrob [3][8];

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   mult_fu #(.NUM_STAGES(1), .PRN_WIDTH(PW), .ROB_CNT_WIDTH(RW)) dut1 (
      .clock(clock), .reset(reset), .squash(squash), .issue_valid(issue_valid),
      .issue_func(issue_func), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
      .issue_dest_prn(issue_dest_prn), .issue_robn(issue_robn), .cdb_avail(cdb_avail),
      .issue_ready(rdy_w[0]), .prepared(prep_w[0]), .out_robn(robn_w[0]),
      .out_dest_prn(prn_w[0]), .out_result(res_w[0]));

   mult_fu #(.NUM_STAGES(4), .PRN_WIDTH(PW), .ROB_CNT_WIDTH(RW)) dut4 (
      .clock(clock), .reset(reset), .squash(squash), .issue_valid(issue_valid),
      .issue_func(issue_func), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
      .issue_dest_prn(issue_dest_prn), .issue_robn(issue_robn), .cdb_avail(cdb_avail),
      .issue_ready(rdy_w[1]), .prepared(prep_w[1]), .out_robn(robn_w[1]),
      .out_dest_prn(prn_w[1]), .out_result(res_w[1]));

   mult_fu #(.NUM_STAGES(8), .PRN_WIDTH(PW), .ROB_CNT_WIDTH(RW)) dut8 (
      .clock(clock), .reset(reset), .squash(squash), .issue_valid(issue_valid),
      .issue_func(issue_func), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
      .issue_dest_prn(issue_dest_prn), .issue_robn(issue_robn), .cdb_avail(cdb_avail),
      .issue_ready(rdy_w[2]), .prepared(prep_w[2]), .out_robn(robn_w[2]),
      .out_dest_prn(prn_w[2]), .out_result(res_w[2]));

   function automatic int nst(input int i);
      return (i == 0) ? 1 : (i == 1) ? 4 : 8;
   endfunction

   // RV32M semantics straight from operand signedness and a full-width product.
   function automatic logic [31:0] ref_result(input logic [1:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
      longint      sa, sb;
      logic [63:0] p;
      sa = (f == 2'b01 || f == 2'b10) ? longint'($signed(a)) : longint'({32'b0, a});
      sb = (f == 2'b01) ? longint'($signed(b)) : longint'({32'b0, b});
      p  = sa * sb;
      return (f == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear(input int i, input bit all_fields);
      for (int k = 0; k < 8; k++) begin
         mv[i][k] = 1'b0;
         if (all_fields) begin
            mres[i][k] = '0;
            mprn[i][k] = '0;
            mrob[i][k] = '0;
         end
      end
   endtask

   // Drive one cycle: check visible outputs, clock the edge, update the model.
   task automatic step(input logic rst, input logic sq, input logic iv, input logic [1:0] f,
                       input logic [31:0] a, input logic [31:0] b, input logic [PW-1:0] prn,
                       input logic [RW-1:0] rob, input logic cdb);
      int   n;
      logic pr;
      reset = rst; squash = sq; issue_valid = iv; issue_func = f;
      issue_rs1 = a; issue_rs2 = b; issue_dest_prn = prn; issue_robn = rob; cdb_avail = cdb;
      #1;
      for (int i = 0; i < 3; i++) begin
         n  = nst(i);
         pr = mv[i][n-1];
         check($sformatf("prepared_n%0d", n), 64'(prep_w[i]), 64'(pr));
         check($sformatf("issue_ready_n%0d", n), 64'(rdy_w[i]), 64'((!pr || cdb) && !sq));
         if (pr) begin
            check($sformatf("result_n%0d", n), 64'(res_w[i]), 64'(mres[i][n-1]));
            check($sformatf("prn_n%0d", n), 64'(prn_w[i]), 64'(mprn[i][n-1]));
            check($sformatf("robn_n%0d", n), 64'(robn_w[i]), 64'(mrob[i][n-1]));
         end
      end
      @(posedge clock);
      for (int i = 0; i < 3; i++) begin
         n  = nst(i);
         pr = mv[i][n-1];
         if (rst) model_clear(i, 1'b1);
         else if (sq) model_clear(i, 1'b0);
         else if (!pr || cdb) begin
            for (int k = n - 1; k > 0; k--) begin
               mv[i][k]   = mv[i][k-1];
               mres[i][k] = mres[i][k-1];
               mprn[i][k] = mprn[i][k-1];
               mrob[i][k] = mrob[i][k-1];
            end
            mv[i][0]   = iv;
            mres[i][0] = ref_result(f, a, b);
            mprn[i][0] = prn;
            mrob[i][0] = rob;
         end
      end
      @(negedge clock);
   endtask

   task automatic idle(input logic cdb);
      step(1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, '0, '0, cdb);
   endtask

   task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [PW-1:0] prn, input logic [RW-1:0] rob);
      step(1'b0, 1'b0, 1'b1, f, a, b, prn, rob, 1'b1);
   endtask

   // Issue one op, wait (bounded) for the depth-4 unit to present it, compare to a constant.
   task automatic run_one(input string tag, input logic [1:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
      int lat;
      issue(f, a, b, 6'd1, 5'd1);
      lat = 1;
      while (!prep_w[1] && lat < 20) begin
         idle(1'b1);
         lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'd4);
      check(tag, 64'(res_w[1]), 64'(exp));
      repeat (8) idle(1'b1);
   endtask

   initial begin
      int          lat;
      int          first [3];
      logic [31:0] fres  [3];
      logic [31:0] fexp  [4];

      reset = 1'b1; squash = 1'b0; issue_valid = 1'b0; issue_func = '0;
      issue_rs1 = '0; issue_rs2 = '0; issue_dest_prn = '0; issue_robn = '0; cdb_avail = 1'b1;
      for (int i = 0; i < 3; i++) model_clear(i, 1'b1);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         check("reset_prepared", 64'(prep_w[i]), 64'd0);
         check("reset_ready", 64'(rdy_w[i]), 64'd1);
         check("reset_result", 64'(res_w[i]), 64'd0);
         check("reset_prn", 64'(prn_w[i]), 64'd0);
         check("reset_robn", 64'(robn_w[i]), 64'd0);
      end
      @(negedge clock);

      // First op: 7 x 6, visible for exactly one cycle.
      issue(2'b00, 32'd7, 32'd6, 6'd5, 5'd3);
      lat = 1;
      while (!prep_w[1] && lat < 20) begin
         idle(1'b1);
         lat++;
      end
      check("first_latency", 64'(lat), 64'd4);
      check("first_result", 64'(res_w[1]), 64'h2A);
      check("first_prn", 64'(prn_w[1]), 64'd5);
      check("first_robn", 64'(robn_w[1]), 64'd3);
      idle(1'b1);
      check("first_gone", 64'(prep_w[1]), 64'd0);
      repeat (8) idle(1'b1);

      fexp[0] = 32'h00000001; fexp[1] = 32'h00000000;
      fexp[2] = 32'hFFFFFFFF; fexp[3] = 32'hFFFFFFFE;
      for (int f = 0; f < 4; f++)
         run_one($sformatf("func%0d_all_ones", f), 2'(f), 32'hFFFFFFFF, 32'hFFFFFFFF, fexp[f]);
      run_one("mulh_min_sq", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000);

      // Back-to-back squares.
      for (int j = 1; j <= 4; j++) issue(2'b00, 32'(j), 32'(j), 6'(j), 5'(j));
      for (int j = 1; j <= 4; j++) begin
         check("b2b_prepared", 64'(prep_w[1]), 64'd1);
         check("b2b_result", 64'(res_w[1]), 64'(j * j));
         idle(1'b1);
      end
      repeat (8) idle(1'b1);

      // Backpressure: full pipe, 3 stalled cycles with offered ops, then drain.
      for (int j = 0; j < 4; j++) issue(2'b00, 32'(10 + j), 32'd3, 6'(j), 5'(j));
      for (int j = 0; j < 3; j++) begin
         step(1'b0, 1'b0, 1'b1, 2'b00, 32'd99, 32'd99, 6'd63, 5'd31, 1'b0);
         check("stall_result", 64'(res_w[1]), 64'd30);
         check("stall_ready", 64'(rdy_w[1]), 64'd0);
      end
      for (int j = 0; j < 4; j++) begin
         check("drain_result", 64'(res_w[1]), 64'((10 + j) * 3));
         idle(1'b1);
      end
      repeat (12) idle(1'b1);

      // Squash with a stalled prepared op; op offered alongside the squash is dropped.
      for (int j = 0; j < 4; j++) issue(2'b00, 32'(j + 2), 32'd2, 6'(j), 5'(j));
      idle(1'b0);
      step(1'b0, 1'b1, 1'b1, 2'b00, 32'd9, 32'd9, 6'd9, 5'd9, 1'b0);
      for (int j = 0; j < 4; j++) begin
         check("squash_empty", 64'(prep_w[1]), 64'd0);
         idle(1'b1);
      end
      repeat (8) idle(1'b1);

      // Reset mid-stream, then latency on every depth.
      for (int j = 0; j < 3; j++) issue(2'b11, 32'(j + 100), 32'd7, 6'(j), 5'(j));
      idle(1'b0);
      step(1'b1, 1'b0, 1'b1, 2'b00, 32'd5, 32'd5, 6'd5, 5'd5, 1'b0);
      #1;
      for (int i = 0; i < 3; i++) begin
         check("midreset_prepared", 64'(prep_w[i]), 64'd0);
         check("midreset_ready", 64'(rdy_w[i]), 64'd1);
         check("midreset_result", 64'(res_w[i]), 64'd0);
         check("midreset_prn", 64'(prn_w[i]), 64'd0);
         check("midreset_robn", 64'(robn_w[i]), 64'd0);
         first[i] = 0;
         fres[i]  = '0;
      end
      issue(2'b00, 32'd3, 32'd5, 6'd2, 5'd2);
      for (lat = 1; lat <= 10; lat++) begin
         for (int i = 0; i < 3; i++)
            if (prep_w[i] && first[i] == 0) begin
               first[i] = lat;
               fres[i]  = res_w[i];
            end
         idle(1'b1);
      end
      for (int i = 0; i < 3; i++) begin
         check($sformatf("post_reset_latency_n%0d", nst(i)), 64'(first[i]), 64'(nst(i)));
         check($sformatf("post_reset_result_n%0d", nst(i)), 64'(fres[i]), 64'd15);
      end

      // Random traffic against the model.
      for (int j = 0; j < 400; j++)
         step(($urandom_range(99) == 0), ($urandom_range(39) == 0), 1'($urandom),
              2'($urandom), $urandom, $urandom, PW'($urandom), RW'($urandom),
              ($urandom_range(3) != 0));
      repeat (10) idle(1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
